// File: rtl/demux2_8_registrado_pkg.sv
// -----------------------------------------------------------------------------
// demux2_8_registrado_pkg
// Shared definitions for the write-back datapath steering blocks.
//   LARGURA_PADRAO      : default data word width (also used by the 2:1 mux)
//   LARGURA_CONT_PADRAO : default width of the per-channel transfer counters
//   canal_e             : destination-select encoding (CANAL0 / CANAL1)
// -----------------------------------------------------------------------------
package demux2_8_registrado_pkg;

    localparam int LARGURA_PADRAO      = 8;
    localparam int LARGURA_CONT_PADRAO = 8;

    typedef enum logic {
        CANAL0 = 1'b0,
        CANAL1 = 1'b1
    } canal_e;

endpackage

// File: rtl/demux2_8_registrado_canal_saida_8.sv
// -----------------------------------------------------------------------------
// canal_saida_8
// One output channel of the registered demux: a 1-entry data register with a
// valid/ready handshake and a wrapping count of accepted words.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   carga        : load dado_in this edge (already qualified by the handshake)
//   dado_in      : word to load
//   pronto       : consumer accepts the held word this cycle
//   dado         : held word (kept after delivery)
//   valido       : dado holds an undelivered word
//   contagem     : number of words loaded since reset (wraps silently)
//   livre        : channel can take a new word this cycle (empty or draining)
// -----------------------------------------------------------------------------
module canal_saida_8
    import demux2_8_registrado_pkg::*;
#(
    parameter int LARGURA      = LARGURA_PADRAO,
    parameter int LARGURA_CONT = LARGURA_CONT_PADRAO
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    carga,
    input  logic [LARGURA-1:0]      dado_in,
    input  logic                    pronto,
    output logic [LARGURA-1:0]      dado,
    output logic                    valido,
    output logic [LARGURA_CONT-1:0] contagem,
    output logic                    livre
);

    logic [LARGURA-1:0]      dado_q,     dado_d;
    logic                    valido_q,   valido_d;
    logic [LARGURA_CONT-1:0] contagem_q, contagem_d;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it
        // unassigned; that is what keeps this block from inferring latches.
        dado_d     = dado_q;
        valido_d   = valido_q;
        contagem_d = contagem_q;

        // A load wins over a drain: when both happen at the same edge the
        // new word replaces the delivered one and valid stays high.
        if (carga) begin
            dado_d     = dado_in;
            valido_d   = 1'b1;
            contagem_d = contagem_q + 1'b1;
        end else if (valido_q && pronto) begin
            valido_d   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the values from before this edge, independent of order.
        if (reset) begin
            // NOTE: the data register is reset as well; it is a single
            // visible register rather than a storage array, and its reset
            // value of zero is observable on the output.
            dado_q     <= '0;
            valido_q   <= 1'b0;
            contagem_q <= '0;
        end else begin
            dado_q     <= dado_d;
            valido_q   <= valido_d;
            contagem_q <= contagem_d;
        end
    end

    assign dado     = dado_q;
    assign valido   = valido_q;
    assign contagem = contagem_q;
    assign livre    = !valido_q || pronto;

endmodule

// File: rtl/demux2_8_registrado.sv
// -----------------------------------------------------------------------------
// demux2_8_registrado
// Steers one source word to one of two registered output channels, selected
// by Controle. Each channel has its own valid/ready handshake and counter.
// Ports:
//   Clock, Reset        : system clock, synchronous active-high reset
//   Entrada             : source word
//   EntradaValida       : source presents a word
//   Controle            : 0 -> channel 0, 1 -> channel 1
//   EntradaPronta       : selected channel can take the word this cycle
//   Saida0/1            : channel data registers
//   Valida0/1           : channel holds an undelivered word
//   Pronta0/1           : channel consumer accepts the held word
//   Contagem0/1         : words accepted into each channel
// -----------------------------------------------------------------------------
module demux2_8_registrado
    import demux2_8_registrado_pkg::*;
#(
    parameter int LARGURA      = LARGURA_PADRAO,
    parameter int LARGURA_CONT = LARGURA_CONT_PADRAO
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [LARGURA-1:0]      Entrada,
    input  logic                    EntradaValida,
    input  logic                    Controle,
    output logic                    EntradaPronta,
    output logic [LARGURA-1:0]      Saida0,
    output logic                    Valida0,
    input  logic                    Pronta0,
    output logic [LARGURA-1:0]      Saida1,
    output logic                    Valida1,
    input  logic                    Pronta1,
    output logic [LARGURA_CONT-1:0] Contagem0,
    output logic [LARGURA_CONT-1:0] Contagem1
);

    canal_e canal;
    logic   livre0, livre1;
    logic   aceita;
    logic   carga0, carga1;

    assign canal = canal_e'(Controle);

    // Only the selected channel can stall the source; the other one is
    // never looked at.
    assign EntradaPronta = !Reset && ((canal == CANAL1) ? livre1 : livre0);
    assign aceita        = EntradaValida && EntradaPronta;
    assign carga0        = aceita && (canal == CANAL0);
    assign carga1        = aceita && (canal == CANAL1);

    canal_saida_8 #(
        .LARGURA      (LARGURA),
        .LARGURA_CONT (LARGURA_CONT)
    ) u_canal0 (
        .clock    (Clock),
        .reset    (Reset),
        .carga    (carga0),
        .dado_in  (Entrada),
        .pronto   (Pronta0),
        .dado     (Saida0),
        .valido   (Valida0),
        .contagem (Contagem0),
        .livre    (livre0)
    );

    canal_saida_8 #(
        .LARGURA      (LARGURA),
        .LARGURA_CONT (LARGURA_CONT)
    ) u_canal1 (
        .clock    (Clock),
        .reset    (Reset),
        .carga    (carga1),
        .dado_in  (Entrada),
        .pronto   (Pronta1),
        .dado     (Saida1),
        .valido   (Valida1),
        .contagem (Contagem1),
        .livre    (livre1)
    );

endmodule
